// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang line-scan blocks.
//   - state_t   : scan FSM encoding (IDLE=0, SCAN=1, DONE=2)
//   - clog2_int : ceiling log2 usable in parameter expressions
//   - max_int   : integer maximum usable in parameter expressions
//   - DEF_*     : default window / run / line counts
package gobang_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIN   = 9;
  localparam int DEF_RUN   = 5;
  localparam int DEF_LINES = 4;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_line_eval.sv
// Combinational evaluation of one line window.
// Finds the lowest start s where RUN consecutive own stones begin. In exact
// mode the run must also be bounded on both sides by a non-own cell or the
// window edge, so longer runs (overlines) are rejected.
// Ports:
//   my    in  WIN  occupancy, 1 = own stone
//   exact in  1    0 = at least RUN, 1 = exactly RUN
//   hit   out 1    a qualifying run exists
//   coord out CW   s + RUN/2 for the winning start, 0 when no hit
module run_line_eval
  import gobang_pkg::*;
#(
  parameter int WIN = DEF_WIN,
  parameter int RUN = DEF_RUN,
  localparam int CW = max_int(1, clog2_int(WIN))
) (
  input  logic [WIN-1:0] my,
  input  logic           exact,
  output logic           hit,
  output logic [CW-1:0]  coord
);

  logic run_ok;
  logic left_ok;
  logic right_ok;

  // Walk starts from high to low so the lowest qualifying start is the
  // last one written and therefore wins.
  always_comb begin
    hit      = 1'b0;
    coord    = '0;
    run_ok   = 1'b0;
    left_ok  = 1'b0;
    right_ok = 1'b0;
    for (int s = WIN - RUN; s >= 0; s--) begin
      run_ok = 1'b1;
      for (int i = 0; i < RUN; i++) begin
        if (!my[s+i]) run_ok = 1'b0;
      end
      // Window edges behave as non-own cells.
      left_ok = 1'b1;
      if (s > 0) left_ok = !my[s-1];
      right_ok = 1'b1;
      if (s + RUN < WIN) right_ok = !my[s+RUN];
      if (run_ok && (!exact || (left_ok && right_ok))) begin
        hit   = 1'b1;
        coord = CW'(s + RUN / 2);
      end
    end
  end

endmodule

// File: rtl/run_scan_checker.sv
// Sequential run checker: accepts LINES line windows in one request, scans
// one line per clock through a single run_line_eval, and presents per-line
// hit flags, centre coordinates and summary fields over valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_my [LINES*WIN]        line k at [k*WIN +: WIN]
//   in_exact                 0 = at least RUN, 1 = exactly RUN
//   out_valid/out_ready      result handshake
//   out_hit [LINES]          per-line hit flags
//   out_coord [LINES*CW]     line k centre at [k*CW +: CW]
//   out_any, out_first, out_count  OR, lowest hit index, number of hits
module run_scan_checker
  import gobang_pkg::*;
#(
  parameter int WIN   = DEF_WIN,
  parameter int RUN   = DEF_RUN,
  parameter int LINES = DEF_LINES,
  localparam int CW = max_int(1, clog2_int(WIN)),
  localparam int LW = max_int(1, clog2_int(LINES)),
  localparam int NW = clog2_int(LINES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LINES*WIN-1:0]  in_my,
  input  logic                  in_exact,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LINES-1:0]      out_hit,
  output logic [LINES*CW-1:0]   out_coord,
  output logic                  out_any,
  output logic [LW-1:0]         out_first,
  output logic [NW-1:0]         out_count
);

  state_t                 state;
  state_t                 state_nxt;
  logic [LW-1:0]          idx;
  logic                   last_line;
  logic [LINES*WIN-1:0]   my_lat;
  logic                   exact_lat;
  logic [WIN-1:0]         line_my;
  logic                   line_hit;
  logic [CW-1:0]          line_coord;
  logic [LINES-1:0]       hit_r;
  logic [LINES*CW-1:0]    coord_r;
  logic                   any_r;
  logic [LW-1:0]          first_r;
  logic [NW-1:0]          count_r;

  assign last_line = (idx == LW'(LINES - 1));
  assign line_my   = my_lat[int'(idx)*WIN +: WIN];

  run_line_eval #(
    .WIN (WIN),
    .RUN (RUN)
  ) u_eval (
    .my    (line_my),
    .exact (exact_lat),
    .hit   (line_hit),
    .coord (line_coord)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (last_line) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Results accumulate line by line, so the summary fields are already
  // final on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      my_lat    <= '0;
      exact_lat <= 1'b0;
      hit_r     <= '0;
      coord_r   <= '0;
      any_r     <= 1'b0;
      first_r   <= '0;
      count_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            my_lat    <= in_my;
            exact_lat <= in_exact;
            idx       <= '0;
            hit_r     <= '0;
            coord_r   <= '0;
            any_r     <= 1'b0;
            first_r   <= '0;
            count_r   <= '0;
          end
        end
        ST_SCAN: begin
          idx <= idx + LW'(1);
          if (line_hit) begin
            hit_r[idx]                  <= 1'b1;
            coord_r[int'(idx)*CW +: CW] <= line_coord;
            if (!any_r) first_r <= idx;
            any_r   <= 1'b1;
            count_r <= count_r + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_hit   = hit_r;
  assign out_coord = coord_r;
  assign out_any   = any_r;
  assign out_first = first_r;
  assign out_count = count_r;

endmodule

// File: tb/tb_run_scan_checker.sv
module tb_run_scan_checker;

  localparam int WIN   = 9;
  localparam int RUN   = 5;
  localparam int LINES = 4;
  localparam int CW    = 4;
  localparam int LW    = 2;
  localparam int NW    = 3;
  localparam int RW    = LINES + LINES*CW + 1 + LW + NW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LINES*WIN-1:0] in_my = '0;
  logic                 in_exact = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [LINES-1:0]     out_hit;
  logic [LINES*CW-1:0]  out_coord;
  logic                 out_any;
  logic [LW-1:0]        out_first;
  logic [NW-1:0]        out_count;

  int checks = 0;
  int failures = 0;

  run_scan_checker #(.WIN(WIN), .RUN(RUN), .LINES(LINES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_my(in_my), .in_exact(in_exact),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_coord(out_coord), .out_any(out_any),
    .out_first(out_first), .out_count(out_count)
  );

  always #5 clk = ~clk;

  wire [RW-1:0] obs = {out_hit, out_coord, out_any, out_first, out_count};

  // Reference: split each line into maximal runs of own stones; the first
  // run whose length qualifies (>= RUN, or == RUN in exact mode) wins, and
  // its start is the lowest qualifying start.
  function automatic logic [RW-1:0] model(input logic [LINES*WIN-1:0] my, input logic ex);
    logic [LINES-1:0]    h;
    logic [LINES*CW-1:0] c;
    int cnt, first, found, len;
    h = '0; c = '0; cnt = 0; first = -1;
    for (int k = 0; k < LINES; k++) begin
      found = -1; len = 0;
      for (int i = 0; i <= WIN; i++) begin
        if (i < WIN && my[k*WIN+i]) len++;
        else begin
          if (len > 0 && found < 0 && (ex ? (len == RUN) : (len >= RUN))) found = i - len;
          len = 0;
        end
      end
      if (found >= 0) begin
        h[k] = 1'b1;
        c[k*CW +: CW] = CW'(found + RUN/2);
        cnt++;
        if (first < 0) first = k;
      end
    end
    return {h, c, (cnt > 0), LW'((first < 0) ? 0 : first), NW'(cnt)};
  endfunction

  // Wait (bounded) for out_valid; lat = edges counted, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Drive one request, wait for its result, capture it, then consume it.
  task automatic transact(input logic [LINES*WIN-1:0] my, input logic ex,
                          output logic [RW-1:0] res, output int lat);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1; in_my = my; in_exact = ex;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    res = obs;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outs: got %h want 0", obs);
    end
  endtask

  task automatic test_directed();
    logic [LINES*WIN-1:0] vec [8];
    logic                 exs [8];
    logic [RW-1:0]        res;
    int                   lat;
    vec[0] = {9'b0, 9'b0, 9'b0, 9'b000011111};         exs[0] = 1'b0;
    vec[1] = {9'b0, 9'b111111000, 9'b0, 9'b0};         exs[1] = 1'b0;
    vec[2] = vec[1];                                   exs[2] = 1'b1;
    vec[3] = {9'b0, 9'b0, 9'b111110111, 9'b0};         exs[3] = 1'b1;
    vec[4] = vec[3];                                   exs[4] = 1'b0;
    vec[5] = {LINES*WIN{1'b1}};                        exs[5] = 1'b0;
    vec[6] = vec[5];                                   exs[6] = 1'b1;
    vec[7] = {9'b000011111, 9'b111110000, 9'b0, 9'b0}; exs[7] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      transact(vec[t], exs[t], res, lat);
      checks++;
      if (lat != LINES) begin
        failures++;
        $display("FAIL dir%0d_latency: got %0d want %0d", t, lat, LINES);
      end
      checks++;
      if (res !== model(vec[t], exs[t])) begin
        failures++;
        $display("FAIL dir%0d_result: got %h want %h", t, res, model(vec[t], exs[t]));
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_release: out_valid=%b in_ready=%b want 0/1", t, out_valid, in_ready);
      end
      // Hand-derived anchors for the first few cases.
      if (t == 0) begin
        checks++;
        if (res !== {4'b0001, 16'h0002, 1'b1, 2'd0, 3'd1}) begin
          failures++;
          $display("FAIL dir0_anchor: got %h", res);
        end
      end
      if (t == 1) begin
        checks++;
        if (res !== {4'b0100, 16'h0500, 1'b1, 2'd2, 3'd1}) begin
          failures++;
          $display("FAIL dir1_anchor: got %h", res);
        end
      end
      if (t == 2 || t == 6) begin
        checks++;
        if (res !== '0) begin
          failures++;
          $display("FAIL dir%0d_overline: got %h want 0", t, res);
        end
      end
      if (t == 3 || t == 4) begin
        checks++;
        if (res !== {4'b0010, 16'h0060, 1'b1, 2'd1, 3'd1}) begin
          failures++;
          $display("FAIL dir%0d_anchor: got %h", t, res);
        end
      end
      if (t == 5) begin
        checks++;
        if (res !== {4'b1111, 16'h2222, 1'b1, 2'd0, 3'd4}) begin
          failures++;
          $display("FAIL dir5_anchor: got %h", res);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [LINES*WIN-1:0] first_req, queued;
    logic [RW-1:0]        snap;
    int                   lat;
    first_req = {9'b0, 9'b011111000, 9'b0, 9'b111110000};
    queued    = {9'b000111110, 9'b0, 9'b0, 9'b0};
    in_valid = 1'b1; in_my = first_req; in_exact = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    checks++;
    if (lat != LINES) begin
      failures++;
      $display("FAIL bp_latency: got %0d want %0d", lat, LINES);
    end
    snap = obs;
    checks++;
    if (snap !== model(first_req, 1'b1)) begin
      failures++;
      $display("FAIL bp_result: got %h want %h", snap, model(first_req, 1'b1));
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_my = {$urandom, $urandom}; in_exact = 1'(i);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: obs=%h ov=%b ir=%b want %h 1 0", i, obs, out_valid, in_ready, snap);
      end
    end
    in_my = queued; in_exact = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_queued_accept: in_ready=%b want 0", in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat != LINES || obs !== model(queued, 1'b0)) begin
      failures++;
      $display("FAIL bp_queued: lat=%0d got %h want %0d %h", lat, obs, LINES, model(queued, 1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic [LINES*WIN-1:0] req;
    logic [RW-1:0]        res;
    int                   lat;
    req = {9'b111110000, 9'b0, 9'b000011111, 9'b0};
    in_valid = 1'b1; in_my = req; in_exact = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      failures++;
      $display("FAIL midrst_state: ov=%b ir=%b obs=%h want 0 1 0", out_valid, in_ready, obs);
    end
    transact(req, 1'b0, res, lat);
    checks++;
    if (lat != LINES || res !== model(req, 1'b0)) begin
      failures++;
      $display("FAIL midrst_fresh: lat=%0d got %h want %0d %h", lat, res, LINES, model(req, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [LINES*WIN-1:0] req;
    logic [WIN-1:0]       ln;
    logic                 ex;
    logic [RW-1:0]        res;
    int                   lat;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < LINES; k++) begin
        case ($urandom_range(0, 3))
          0: ln = WIN'($urandom);
          1: ln = WIN'($urandom | $urandom | $urandom);
          2: begin ln = '1; ln[$urandom_range(0, WIN-1)] = 1'b0; end
          default: ln = '0;
        endcase
        req[k*WIN +: WIN] = ln;
      end
      ex = 1'($urandom);
      transact(req, ex, res, lat);
      checks++;
      if (lat != LINES || res !== model(req, ex)) begin
        failures++;
        $display("FAIL rand%0d: lat=%0d got %h want %0d %h (my=%h ex=%b)", n, lat, res, LINES, model(req, ex), req, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
